step_dir_gen: RTL
=================

Name: step_dir_gen

Overview:
- Step/direction pulse generator: the transmit side of the step/dir interface that the phase decoder consumes.
- Accepts a motion command over a valid/ready handshake: step count, direction, step period in clocks.
- Emits `step` pulses with guaranteed pulse width, low time and direction setup.
- Sits between the motion planner and the motor driver pins (or a loopback into the phase decoder).

Parameters:
- CNT_WIDTH, 16, width of the step count and of `steps_left`.
- PER_WIDTH, 16, width of the step period in clocks.
- PULSE_CLKS, 7, `step` high time in clocks (about 100 ns at 72 MHz); must be at least 1.
- DIR_SETUP_CLKS, 7, clocks between a `dir` change and the next `step` rising edge; must be at least 1.
- POS_WIDTH, 32, width of the position counter (optional feature only).

Ports:
- clk  in  1  system clock (72 MHz)
- aclr  in  1  asynchronous reset, active-high
- sclr  in  1  synchronous clear, active-high; same effect as aclr at the next clk edge
- cmd_valid  in  1  command offered
- cmd_ready  out  1  generator idle and able to accept a command
- cmd_steps  in  CNT_WIDTH  number of steps to issue
- cmd_dir  in  1  requested direction
- cmd_period  in  PER_WIDTH  clocks between `step` rising edges
- abort  in  1  stop the current command early
- step  out  1  step pulse, registered
- dir  out  1  direction, registered
- busy  out  1  command in progress
- done  out  1  one-cycle completion strobe
- steps_left  out  CNT_WIDTH  steps not yet issued

Behaviour:
- Reset (aclr async, sclr sync) values: step=0, dir=0, busy=0, done=0, steps_left=0, cmd_ready=0, state=IDLE. cmd_ready rises on the first clk edge after reset is released.
- All outputs are registered.
- Acceptance: a command is accepted on a clk edge where cmd_valid=1 and cmd_ready=1. At that edge:
  - latch cmd_steps, cmd_dir and P = max(cmd_period, 2*PULSE_CLKS);
  - drive cmd_ready=0.
- IDLE, handling of the accepted command:
  - cmd_steps==0: done=1 for one cycle, busy stays 0, stay in IDLE; cmd_ready=1 again on the cycle after done.
  - cmd_dir != dir: dir<=cmd_dir, busy<=1, steps_left<=cmd_steps, go to SETUP.
  - Otherwise: step<=1, busy<=1, steps_left<=cmd_steps, go to HIGH. `step` is therefore high in the first cycle after the acceptance edge.
- SETUP: hold step=0 for DIR_SETUP_CLKS cycles, then step<=1, go to HIGH.
- HIGH: step=1 for exactly PULSE_CLKS cycles, then step<=0 and steps_left decrements by 1; go to LOW.
- LOW:
  - step=0 until P cycles have elapsed since the last `step` rising edge.
  - If steps_left==0: done<=1 for one cycle, busy<=0, go to IDLE; cmd_ready<=1 on the following cycle.
  - Else: step<=1, go to HIGH.
- Timing: consecutive `step` rising edges are exactly P clocks apart. dir never changes while step=1 or during LOW/HIGH of a command.
- abort:
  - Sampled in SETUP or LOW: next edge goes to IDLE with done=1, busy=0, step=0; steps_left freezes at its current value.
  - Sampled in HIGH: the pulse completes its full PULSE_CLKS (with decrement), then the abort takes effect.
  - Ignored in IDLE.
- cmd_valid while busy: ignored; cmd_ready=0 and the inputs are not latched.
- aclr mid-pulse: step drops to 0 immediately, asynchronously. dir returns to 0.
- Counter widths: the period counter is PER_WIDTH+1 bits so that 2*PULSE_CLKS cannot overflow. steps_left never wraps below 0.

Optional Feature:
- Macro: STEP_DIR_GEN_POS_EN.
- Defined:
  - adds output `pos` [POS_WIDTH-1:0], signed, reset 0;
  - on each `step` rising edge, pos increments by 1 when dir=1 and decrements by 1 when dir=0;
  - two's-complement wrap at the limits;
  - sclr clears it.
- Not defined: the `pos` port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold aclr/sclr 10 clks -> step=0, dir=0, busy=0, done=0, steps_left=0; cmd_ready=1 one clk after release.
- cmd_steps=3, cmd_dir=0, cmd_period=20 -> no setup delay; step high 7 clks starting the cycle after acceptance; rising edges 20 clks apart; steps_left 3→2→1→0; done pulses 1 clk, 20 clks after the third rising edge; busy low with it.
- cmd_steps=2, cmd_dir=1 from dir=0 -> dir=1 the cycle after acceptance; first step rise 7 clks later; 2 pulses; dir stays 1 after done.
- cmd_period=5 -> clamped; rising edges 14 clks apart, high 7, low 7.
- cmd_steps=0 -> done=1 the cycle after acceptance; step never rises; busy stays 0.
- cmd_steps=10, abort asserted for 1 clk during the 4th pulse's HIGH -> the 4th pulse completes 7 clks; then done, steps_left=6, busy=0.
- With STEP_DIR_GEN_POS_EN: 35 steps dir=0, then 35 steps dir=1 -> pos=-35, then 0.

Source files
------------

// File: rtl/step_dir_gen.sv
// Step/direction pulse generator: turns a (steps, dir, period) command into timed step pulses.
// Optional signed position counter enabled by defining STEP_DIR_GEN_POS_EN.
module step_dir_gen #(
    parameter int CNT_WIDTH      = 16,
    parameter int PER_WIDTH      = 16,
    parameter int PULSE_CLKS     = 7,
    parameter int DIR_SETUP_CLKS = 7,
    parameter int POS_WIDTH      = 32
) (
    input  logic                        clk,
    input  logic                        aclr,
    input  logic                        sclr,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [CNT_WIDTH-1:0]        cmd_steps,
    input  logic                        cmd_dir,
    input  logic [PER_WIDTH-1:0]        cmd_period,
    input  logic                        abort,
    output logic                        step,
    output logic                        dir,
    output logic                        busy,
    output logic                        done,
`ifdef STEP_DIR_GEN_POS_EN
    output logic signed [POS_WIDTH-1:0] pos,
`endif
    output logic [CNT_WIDTH-1:0]        steps_left
);

    // One extra bit so 2*PULSE_CLKS never overflows the period counter
    localparam int CW = PER_WIDTH + 1;
    localparam logic [CW-1:0] MIN_PER    = CW'(2 * PULSE_CLKS);
    localparam logic [CW-1:0] HIGH_LAST  = CW'(PULSE_CLKS);
    localparam logic [CW-1:0] SETUP_LAST = CW'(DIR_SETUP_CLKS);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        per, per_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [CNT_WIDTH-1:0] left_nxt;
    logic                 step_nxt, dir_nxt, busy_nxt, done_nxt, ready_nxt;
    logic                 abort_pend, abort_pend_nxt;
    logic                 accept;

    function automatic logic [CW-1:0] clamp_period(input logic [PER_WIDTH-1:0] p);
        logic [CW-1:0] ext;
        ext = {1'b0, p};
        return (ext < MIN_PER) ? MIN_PER : ext;
    endfunction

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_nxt      = state;
        per_nxt        = per;
        cnt_nxt        = cnt + CW'(1);
        left_nxt       = steps_left;
        step_nxt       = step;
        dir_nxt        = dir;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        ready_nxt      = 1'b0;
        abort_pend_nxt = abort_pend;

        case (state)
            IDLE: begin
                ready_nxt      = !accept;
                cnt_nxt        = cnt;
                abort_pend_nxt = 1'b0;
                if (accept) begin
                    per_nxt = clamp_period(cmd_period);
                    if (cmd_steps == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        busy_nxt = 1'b1;
                        left_nxt = cmd_steps;
                        cnt_nxt  = CW'(1);
                        if (cmd_dir != dir) begin
                            dir_nxt   = cmd_dir;
                            state_nxt = SETUP;
                        end else begin
                            step_nxt  = 1'b1;
                            state_nxt = HIGH;
                        end
                    end
                end
            end
            SETUP: begin
                if (abort) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    step_nxt  = 1'b0;
                end else if (cnt == SETUP_LAST) begin
                    step_nxt  = 1'b1;
                    cnt_nxt   = CW'(1);
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (abort) abort_pend_nxt = 1'b1;
                // An abort seen during the pulse takes effect only once the pulse has completed
                if (cnt == HIGH_LAST) begin
                    step_nxt = 1'b0;
                    if (steps_left != '0) left_nxt = steps_left - CNT_WIDTH'(1);
                    if (abort || abort_pend) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                    end else begin
                        state_nxt = LOW;
                    end
                end
            end
            LOW: begin
                if (abort || (cnt == per && steps_left == '0)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    step_nxt  = 1'b0;
                end else if (cnt == per) begin
                    step_nxt  = 1'b1;
                    cnt_nxt   = CW'(1);
                    state_nxt = HIGH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state <= IDLE;
        end else if (sclr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            per        <= '0;
            cnt        <= '0;
            steps_left <= '0;
            step       <= 1'b0;
            dir        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cmd_ready  <= 1'b0;
            abort_pend <= 1'b0;
        end else if (sclr) begin
            per        <= '0;
            cnt        <= '0;
            steps_left <= '0;
            step       <= 1'b0;
            dir        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cmd_ready  <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            per        <= per_nxt;
            cnt        <= cnt_nxt;
            steps_left <= left_nxt;
            step       <= step_nxt;
            dir        <= dir_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            cmd_ready  <= ready_nxt;
            abort_pend <= abort_pend_nxt;
        end
    end

`ifdef STEP_DIR_GEN_POS_EN
    // dir is stable across every rising edge, so the current value gives the move direction
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            pos <= '0;
        end else if (sclr) begin
            pos <= '0;
        end else if (step_nxt && !step) begin
            pos <= dir ? pos + POS_WIDTH'(1) : pos - POS_WIDTH'(1);
        end
    end
`endif

endmodule
